// File: rtl/pc_select_reg.sv
// Next-PC unit: N-way PC-source mux, PC/prev-PC registers, and a one-cycle exception
// entry sequencer that captures EPC, rejected target address and fault cause.
module pc_select_reg #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NUM_SRC    = 5,
  parameter int unsigned      SEL_W      = 3,
  parameter int unsigned      ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat_i,
  input  logic [SEL_W-1:0]         pcsrc_sel_i,
  input  logic                     pc_write_i,
  input  logic                     pc_write_cond_i,
  input  logic                     branch_taken_i,
  input  logic                     exc_req_i,
  input  logic [WIDTH-1:0]         exc_vector_i,
  output logic [WIDTH-1:0]         pc_o,
  output logic [WIDTH-1:0]         pc_prev_o,
  output logic [WIDTH-1:0]         epc_o,
  output logic [WIDTH-1:0]         badaddr_o,
  output logic                     exc_active_o,
  output logic [1:0]               fault_cause_o
);

  typedef enum logic [0:0] {StRun, StEntry} state_e;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseExternal = 2'b01;
  localparam logic [1:0] CauseMisalign = 2'b10;
  localparam logic [1:0] CauseBadSel   = 2'b11;

  // ALIGN_BITS = 0 yields an all-zero mask, which disables the alignment check.
  localparam logic [WIDTH-1:0] AlignMask = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [SEL_W:0]   NumSrcW   = (SEL_W + 1)'(NUM_SRC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_prev_q, pc_prev_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] badaddr_q, badaddr_d;
  logic [1:0]       cause_q, cause_d;

  logic [WIDTH-1:0] target;
  logic             bad_sel;
  logic             misaligned;
  logic             do_write;

  always_comb begin
    target = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pcsrc_sel_i == SEL_W'(i)) begin
        target = src_flat_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign bad_sel    = {1'b0, pcsrc_sel_i} >= NumSrcW;
  assign misaligned = |(target & AlignMask);
  assign do_write   = pc_write_i | (pc_write_cond_i & branch_taken_i);

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      pc_q      <= RESET_VEC;
      pc_prev_q <= RESET_VEC;
      epc_q     <= '0;
      badaddr_q <= '0;
      cause_q   <= CauseNone;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_prev_q <= pc_prev_d;
      epc_q     <= epc_d;
      badaddr_q <= badaddr_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state logic; faults take priority over a normal write.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_prev_d = pc_prev_q;
    epc_d     = epc_q;
    badaddr_d = badaddr_q;
    cause_d   = cause_q;
    unique case (state_q)
      StRun: begin
        if (exc_req_i) begin
          epc_d   = pc_q;
          cause_d = CauseExternal;
          state_d = StEntry;
        end else if (do_write && bad_sel) begin
          epc_d   = pc_q;
          cause_d = CauseBadSel;
          state_d = StEntry;
        end else if (do_write && misaligned) begin
          badaddr_d = target;
          epc_d     = pc_q;
          cause_d   = CauseMisalign;
          state_d   = StEntry;
        end else if (do_write) begin
          pc_prev_d = pc_q;
          pc_d      = target;
        end
      end
      StEntry: begin
        pc_prev_d = pc_q;
        pc_d      = exc_vector_i;
        state_d   = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    exc_active_o  = (state_q == StEntry);
    pc_o          = pc_q;
    pc_prev_o     = pc_prev_q;
    epc_o         = epc_q;
    badaddr_o     = badaddr_q;
    fault_cause_o = cause_q;
  end

endmodule

// File: tb/tb_pc_select_reg.sv
// Directed scoreboard bench for pc_select_reg: the driver queues hand-computed post-edge
// state per vector, the monitor pops and compares one entry after every rising edge.
module tb_pc_select_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = 5;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] prev;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        act;
    logic [1:0]  cause;
    logic        chk0;
    logic [31:0] pc0;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS*W-1:0] src_flat = '0;
  logic [2:0]      sel = '0;
  logic            pw = 1'b0, pwc = 1'b0, bt = 1'b0, er = 1'b0;
  logic [W-1:0]    ev = '0;

  logic [W-1:0] pc, prev, epc, bad, pc0, prev0, epc0, bad0;
  logic         act, act0;
  logic [1:0]   cause, cause0;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  pc_select_reg #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(3), .ALIGN_BITS(2), .RESET_VEC('0)) u_dut (
    .clk_i(clk), .rst_i(rst), .src_flat_i(src_flat), .pcsrc_sel_i(sel), .pc_write_i(pw),
    .pc_write_cond_i(pwc), .branch_taken_i(bt), .exc_req_i(er), .exc_vector_i(ev),
    .pc_o(pc), .pc_prev_o(prev), .epc_o(epc), .badaddr_o(bad), .exc_active_o(act),
    .fault_cause_o(cause)
  );

  // Alignment check disabled; only compared where flagged in the vector.
  pc_select_reg #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(3), .ALIGN_BITS(0), .RESET_VEC('0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .src_flat_i(src_flat), .pcsrc_sel_i(sel), .pc_write_i(pw),
    .pc_write_cond_i(pwc), .branch_taken_i(bt), .exc_req_i(er), .exc_vector_i(ev),
    .pc_o(pc0), .pc_prev_o(prev0), .epc_o(epc0), .badaddr_o(bad0), .exc_active_o(act0),
    .fault_cause_o(cause0)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".pc"}, pc, e.pc);
      chk({e.name, ".pc_prev"}, prev, e.prev);
      chk({e.name, ".epc"}, epc, e.epc);
      chk({e.name, ".badaddr"}, bad, e.bad);
      chk({e.name, ".exc_active"}, {31'b0, act}, {31'b0, e.act});
      chk({e.name, ".cause"}, {30'b0, cause}, {30'b0, e.cause});
      if (e.chk0) chk({e.name, ".pc_noalign"}, pc0, e.pc0);
    end
  end

  task automatic step(input string nm, input logic [2:0] s, input logic w, input logic wc,
                      input logic b, input logic x, input logic [31:0] tgt,
                      input logic [31:0] vec, input logic [31:0] e_pc,
                      input logic [31:0] e_prev, input logic [31:0] e_epc,
                      input logic [31:0] e_bad, input logic e_act, input logic [1:0] e_cause,
                      input logic c0 = 1'b0, input logic [31:0] e_pc0 = '0);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < int'(NS); i++) src_flat[i*W +: W] = 32'hDEAD_0001 + i;
    if (int'(s) < int'(NS)) src_flat[int'(s)*W +: W] = tgt;
    sel = s; pw = w; pwc = wc; bt = b; er = x; ev = vec;
    e.name = nm; e.pc = e_pc; e.prev = e_prev; e.epc = e_epc; e.bad = e_bad;
    e.act = e_act; e.cause = e_cause; e.chk0 = c0; e.pc0 = e_pc0;
    sb.push_back(e);
  endtask

  // Idle inputs at a negedge, then raise reset mid-cycle and check without a clock edge.
  task automatic async_reset(input string nm);
    @(negedge clk);
    sel = '0; pw = 1'b0; pwc = 1'b0; bt = 1'b0; er = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk({nm, ".pc"}, pc, 32'h0);
    chk({nm, ".pc_prev"}, prev, 32'h0);
    chk({nm, ".epc"}, epc, 32'h0);
    chk({nm, ".cause"}, {30'b0, cause}, 32'h0);
    chk({nm, ".exc_active"}, {31'b0, act}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.pc", pc, 32'h0);
    chk("rst.badaddr", bad, 32'h0);
    rst = 1'b0;

    //   name   sel pw pwc bt er target        exc_vec      pc            pc_prev       epc     bad   act cause
    step("a1", 3'd1, 1, 0, 0, 0, 32'h0040_0100, 32'h0,       32'h0040_0100, 32'h0,        32'h0,  32'h0, 0, 2'b00);
    step("a2", 3'd0, 0, 1, 0, 0, 32'h1234_5678, 32'h0,       32'h0040_0100, 32'h0,        32'h0,  32'h0, 0, 2'b00);
    step("a3", 3'd2, 1, 0, 0, 0, 32'h80,        32'h0,       32'h80,        32'h0040_0100, 32'h0, 32'h0, 0, 2'b00);
    step("a4", 3'd1, 1, 0, 0, 1, 32'h100,       32'h0,       32'h80,        32'h0040_0100, 32'h80, 32'h0, 1, 2'b01);
    step("a5", 3'd1, 1, 0, 0, 1, 32'h200,       32'hFF,      32'hFF,        32'h80,       32'h80, 32'h0, 0, 2'b01);
    step("a6", 3'd0, 0, 0, 0, 0, 32'h0,         32'h0,       32'hFF,        32'h80,       32'h80, 32'h0, 0, 2'b01);
    step("a7", 3'd2, 0, 1, 1, 0, 32'h40,        32'h0,       32'h40,        32'hFF,       32'h80, 32'h0, 0, 2'b01);
    async_reset("t1");

    step("b1", 3'd0, 1, 0, 0, 0, 32'h102,       32'h0,       32'h0,   32'h0,   32'h0,   32'h102, 1, 2'b10, 1, 32'h102);
    step("b2", 3'd0, 0, 0, 0, 0, 32'h0,         32'h3C0,     32'h3C0, 32'h0,   32'h0,   32'h102, 0, 2'b10);
    step("b3", 3'd6, 0, 0, 0, 0, 32'h0,         32'h0,       32'h3C0, 32'h0,   32'h0,   32'h102, 0, 2'b10);
    step("b4", 3'd6, 1, 0, 0, 0, 32'h0,         32'h0,       32'h3C0, 32'h0,   32'h3C0, 32'h102, 1, 2'b11);
    step("b5", 3'd1, 0, 1, 1, 0, 32'h500,       32'h400,     32'h400, 32'h3C0, 32'h3C0, 32'h102, 0, 2'b11);
    step("b6", 3'd4, 1, 0, 0, 0, 32'h800,       32'h0,       32'h800, 32'h400, 32'h3C0, 32'h102, 0, 2'b11);
    step("b7", 3'd5, 1, 0, 0, 0, 32'h0,         32'h0,       32'h800, 32'h400, 32'h800, 32'h102, 1, 2'b11);
    step("b8", 3'd0, 0, 0, 0, 1, 32'h0,         32'h900,     32'h900, 32'h800, 32'h800, 32'h102, 0, 2'b11);
    step("b9", 3'd0, 0, 0, 0, 0, 32'h0,         32'h0,       32'h900, 32'h800, 32'h800, 32'h102, 0, 2'b11);
    step("b10", 3'd0, 0, 0, 0, 1, 32'h0,        32'h0,       32'h900, 32'h800, 32'h900, 32'h102, 1, 2'b01);
    async_reset("t6");

    step("c1", 3'd0, 0, 0, 0, 0, 32'h0,         32'hABC,     32'h0,   32'h0,   32'h0,   32'h0,   0, 2'b00);
    step("c2", 3'd3, 1, 0, 0, 0, 32'h44,        32'h0,       32'h44,  32'h0,   32'h0,   32'h0,   0, 2'b00);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
